fault_recovery_sequencer: RTL and testbench

- Top-level recovery FSM for the fault-tolerant core. It sequences detection, safe mode, PC rollback, retry and resume, and gates the pipeline write enables while doing so.
- Owns the checkpoint PC, the bounded retry counter and a sticky fault cause.
- Sits between the fault detectors (opcode checker, control checker, stuck-at monitor) and the fetch/writeback controls. Its safe_mode, recover_cpu and resume_cpu outputs feed the existing fault assertion checker.

---
 rtl/ft_pkg.sv | 19 +
 rtl/ft_fault_encoder.sv | 25 ++
 rtl/fault_recovery_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fault_recovery_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared types for the fault-recovery logic: sequencer states and the
// fault_cause encoding seen by software.
package ft_pkg;

   typedef enum logic [2:0] {
      NORMAL   = 3'd0,
      SAFE     = 3'd1,
      ROLLBACK = 3'd2,
      RETRY    = 3'd3,
      RESUME   = 3'd4,
      HALT     = 3'd5
   } ft_state_e;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_CTRL    = 2'd2;
   localparam logic [1:0] CAUSE_STUCK   = 2'd3;

endpackage

// File: rtl/ft_fault_encoder.sv
// Merges the three detector flags into one fault strobe plus a cause code,
// with stuck-at taking precedence over control, control over opcode.
module ft_fault_encoder
   import ft_pkg::*;
(
   input  logic       illegal_opcode,
   input  logic       invalid_control,
   input  logic       stuck_at_fault,
   output logic       fault,
   output logic [1:0] cause
);

   assign fault = illegal_opcode | invalid_control | stuck_at_fault;

   always_comb begin
      cause = CAUSE_NONE;
      if (stuck_at_fault)
         cause = CAUSE_STUCK;
      else if (invalid_control)
         cause = CAUSE_CTRL;
      else if (illegal_opcode)
         cause = CAUSE_ILLEGAL;
   end

endmodule

// File: rtl/fault_recovery_sequencer.sv
// Recovery FSM: drains the pipeline on a fault, rolls fetch back to the last
// clean checkpoint, retries a bounded number of times and halts if retries run out.
module fault_recovery_sequencer
   import ft_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int RETRY_WINDOW = 8,
   parameter int MAX_RETRIES  = 2,
   parameter int CNT_W        = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             illegal_opcode,
   input  logic             invalid_control,
   input  logic             stuck_at_fault,
   input  logic             instr_commit,
   input  logic [31:0]      pc_current,
   input  logic             pc_write_normal,
   input  logic             reg_write_normal,
   input  logic             mem_write_normal,
   input  logic             clear_halt,
   output logic             pc_write_out,
   output logic             reg_write_out,
   output logic             mem_write_out,
   output logic [31:0]      pc_restore,
   output logic             pc_restore_en,
   output logic             insert_nop,
   output logic             safe_mode,
   output logic             retry_en,
   output logic             recover_cpu,
   output logic             resume_cpu,
   output logic             halted,
   output logic [1:0]       fault_cause,
   output logic [CNT_W-1:0] retry_count
);

   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(RETRY_WINDOW - 1);
   localparam logic [CNT_W-1:0] RETRY_LAST  = CNT_W'(MAX_RETRIES - 1);

   ft_state_e        state_reg, state_next;
   logic [CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
   logic [CNT_W-1:0] win_cnt_reg, win_cnt_next;
   logic [CNT_W-1:0] retry_cnt_reg, retry_cnt_next;
   logic [1:0]       cause_reg, cause_next;
   logic [31:0]      pc_restore_reg, pc_restore_next;

   logic       fault;
   logic [1:0] enc_cause;
   logic       pass_en;
   logic       force_pc;
   logic [2:0] write_normal, write_force, write_out;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   ft_fault_encoder u_fault_encoder (
      .illegal_opcode  (illegal_opcode),
      .invalid_control (invalid_control),
      .stuck_at_fault  (stuck_at_fault),
      .fault           (fault),
      .cause           (enc_cause)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= NORMAL;
         drain_cnt_reg  <= '0;
         win_cnt_reg    <= '0;
         retry_cnt_reg  <= '0;
         cause_reg      <= CAUSE_NONE;
         pc_restore_reg <= '0;
      end else begin
         state_reg      <= state_next;
         drain_cnt_reg  <= drain_cnt_next;
         win_cnt_reg    <= win_cnt_next;
         retry_cnt_reg  <= retry_cnt_next;
         cause_reg      <= cause_next;
         pc_restore_reg <= pc_restore_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      drain_cnt_next  = drain_cnt_reg;
      win_cnt_next    = win_cnt_reg;
      retry_cnt_next  = retry_cnt_reg;
      cause_next      = cause_reg;
      pc_restore_next = pc_restore_reg;
      pass_en         = 1'b0;
      force_pc        = 1'b0;
      pc_restore_en   = 1'b0;
      insert_nop      = 1'b0;
      safe_mode       = 1'b0;
      retry_en        = 1'b0;
      recover_cpu     = 1'b0;
      resume_cpu      = 1'b0;
      halted          = 1'b0;

      case (state_reg)
         NORMAL: begin
            pass_en = 1'b1;
            // A commit racing a fault may be the faulting instruction itself.
            if (fault) begin
               state_next     = SAFE;
               cause_next     = enc_cause;
               drain_cnt_next = '0;
            end else if (instr_commit) begin
               pc_restore_next = pc_current;
            end
         end
         SAFE: begin
            insert_nop = 1'b1;
            safe_mode  = 1'b1;
            if (drain_cnt_reg >= DRAIN_LAST)
               state_next = ROLLBACK;
            else
               drain_cnt_next = sat_inc(drain_cnt_reg);
         end
         ROLLBACK: begin
            force_pc      = 1'b1;
            pc_restore_en = 1'b1;
            recover_cpu   = 1'b1;
            safe_mode     = 1'b1;
            win_cnt_next  = '0;
            state_next    = RETRY;
         end
         RETRY: begin
            pass_en  = 1'b1;
            retry_en = 1'b1;
            if (fault) begin
               cause_next = enc_cause;
               if (retry_cnt_reg >= RETRY_LAST) begin
                  state_next = HALT;
               end else begin
                  retry_cnt_next = sat_inc(retry_cnt_reg);
                  drain_cnt_next = '0;
                  state_next     = SAFE;
               end
            end else if (win_cnt_reg >= WINDOW_LAST) begin
               state_next = RESUME;
            end else begin
               win_cnt_next = sat_inc(win_cnt_reg);
            end
         end
         RESUME: begin
            pass_en        = 1'b1;
            resume_cpu     = 1'b1;
            retry_cnt_next = '0;
            state_next     = NORMAL;
         end
         HALT: begin
            insert_nop = 1'b1;
            halted     = 1'b1;
            if (clear_halt) begin
               state_next     = NORMAL;
               retry_cnt_next = '0;
               cause_next     = CAUSE_NONE;
            end
         end
         default: state_next = NORMAL;
      endcase
   end

   // Bit 2 is the PC enable, the only one rollback forces high.
   assign write_normal = {pc_write_normal, reg_write_normal, mem_write_normal};
   assign write_force  = {force_pc, 2'b00};

   for (genvar gi = 0; gi < 3; gi++) begin : g_gate
      assign write_out[gi] = (write_normal[gi] & pass_en) | write_force[gi];
   end

   assign {pc_write_out, reg_write_out, mem_write_out} = write_out;
   assign pc_restore  = pc_restore_reg;
   assign fault_cause = cause_reg;
   assign retry_count = retry_cnt_reg;

endmodule

// File: tb/tb_fault_recovery_sequencer.sv
// Scoreboard bench for fault_recovery_sequencer: each driven cycle queues the
// output picture expected after the next clock edge, compared once it arrives.
module tb_fault_recovery_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        illegal_opcode = 1'b0, invalid_control = 1'b0, stuck_at_fault = 1'b0;
   logic        instr_commit = 1'b0;
   logic [31:0] pc_current = '0;
   logic        pc_write_normal = 1'b0, reg_write_normal = 1'b0, mem_write_normal = 1'b0;
   logic        clear_halt = 1'b0;
   logic        pc_write_out, reg_write_out, mem_write_out;
   logic [31:0] pc_restore;
   logic        pc_restore_en, insert_nop, safe_mode, retry_en;
   logic        recover_cpu, resume_cpu, halted;
   logic [1:0]  fault_cause;
   logic [3:0]  retry_count;

   always #5 clk = ~clk;

   fault_recovery_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .illegal_opcode   (illegal_opcode),
      .invalid_control  (invalid_control),
      .stuck_at_fault   (stuck_at_fault),
      .instr_commit     (instr_commit),
      .pc_current       (pc_current),
      .pc_write_normal  (pc_write_normal),
      .reg_write_normal (reg_write_normal),
      .mem_write_normal (mem_write_normal),
      .clear_halt       (clear_halt),
      .pc_write_out     (pc_write_out),
      .reg_write_out    (reg_write_out),
      .mem_write_out    (mem_write_out),
      .pc_restore       (pc_restore),
      .pc_restore_en    (pc_restore_en),
      .insert_nop       (insert_nop),
      .safe_mode        (safe_mode),
      .retry_en         (retry_en),
      .recover_cpu      (recover_cpu),
      .resume_cpu       (resume_cpu),
      .halted           (halted),
      .fault_cause      (fault_cause),
      .retry_count      (retry_count)
   );

   typedef enum {S_NORMAL, S_SAFE, S_ROLLBACK, S_RETRY, S_RESUME, S_HALT} tb_st_e;

   typedef struct {
      logic [9:0]  flags;
      logic [31:0] pc;
      logic [5:0]  misc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          txn = 0;
   logic [31:0] exp_pc = '0;
   logic [1:0]  exp_cause = '0;
   logic [3:0]  exp_rc = '0;

   // {pc_w, reg_w, mem_w, nop, safe, pc_en, recover, resume, retry_en, halted}
   logic [9:0] obs_flags;
   assign obs_flags = {pc_write_out, reg_write_out, mem_write_out, insert_nop, safe_mode,
                       pc_restore_en, recover_cpu, resume_cpu, retry_en, halted};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   function automatic exp_t mk(input tb_st_e st, input logic [2:0] wn);
      exp_t e;
      case (st)
         S_NORMAL:   e.flags = {wn,     7'b0000000};
         S_SAFE:     e.flags = {3'b000, 7'b1100000};
         S_ROLLBACK: e.flags = {3'b100, 7'b0111000};
         S_RETRY:    e.flags = {wn,     7'b0000010};
         S_RESUME:   e.flags = {wn,     7'b0000100};
         default:    e.flags = {3'b000, 7'b1000001};
      endcase
      e.pc   = exp_pc;
      e.misc = {exp_cause, exp_rc};
      return e;
   endfunction

   // flt = {stuck, ctrl, illegal}; st is the state expected after the next edge.
   task automatic cyc(input string tag, input tb_st_e st, input logic [2:0] flt,
                      input logic commit, input logic [31:0] pc, input logic clr);
      exp_t        e;
      logic [2:0]  wn;
      @(negedge clk);
      {stuck_at_fault, invalid_control, illegal_opcode} = flt;
      instr_commit = commit;
      pc_current   = pc;
      clear_halt   = clr;
      wn = 3'($urandom_range(0, 7));
      {pc_write_normal, reg_write_normal, mem_write_normal} = wn;
      sb.push_back(mk(st, wn));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      txn++;
      $display("txn %0d %s expect %s", txn, tag, st.name());
      check_eq({tag, ".flags"}, 64'(obs_flags), 64'(e.flags));
      check_eq({tag, ".pc_restore"}, 64'(pc_restore), 64'(e.pc));
      check_eq({tag, ".cause_retries"}, 64'({fault_cause, retry_count}), 64'(e.misc));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".flags"}, 64'(obs_flags), 64'd0);
      check_eq({tag, ".pc_restore"}, 64'(pc_restore), 64'd0);
      check_eq({tag, ".cause_retries"}, 64'({fault_cause, retry_count}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;

      // Checkpoint, single fault, full recovery.
      exp_pc = 32'h10; cyc("commit10", S_NORMAL, 3'b000, 1'b1, 32'h10, 1'b0);
      exp_pc = 32'h14; cyc("commit14", S_NORMAL, 3'b000, 1'b1, 32'h14, 1'b0);
      exp_cause = 2'd1; cyc("illegal", S_SAFE, 3'b001, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) cyc("drain", S_SAFE, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("rollback", S_ROLLBACK, 3'b000, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) cyc("window_frozen", S_RETRY, 3'b000, 1'b1, 32'h99, 1'b0);
      cyc("resume", S_RESUME, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("back_normal", S_NORMAL, 3'b000, 1'b0, 32'h0, 1'b0);

      // Commit racing a fault is not checkpointed; held faults don't extend drain.
      exp_cause = 2'd3; cyc("stuck_commit20", S_SAFE, 3'b101, 1'b1, 32'h20, 1'b0);
      for (int i = 0; i < 2; i++) cyc("held_faults", S_SAFE, 3'b111, 1'b0, 32'h0, 1'b0);
      cyc("rollback_held", S_ROLLBACK, 3'b111, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) cyc("retry_clean", S_RETRY, 3'b000, 1'b0, 32'h0, 1'b0);

      // Fault in RETRY cycle 4, then a clean retry.
      exp_rc = 4'd1; exp_cause = 2'd2; cyc("retry_fault", S_SAFE, 3'b010, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) cyc("drain2", S_SAFE, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("rollback2", S_ROLLBACK, 3'b000, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) cyc("window2", S_RETRY, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("resume2", S_RESUME, 3'b000, 1'b0, 32'h0, 1'b0);
      exp_rc = 4'd0; cyc("retries_cleared", S_NORMAL, 3'b000, 1'b0, 32'h0, 1'b0);

      // Two consecutive failed retries end in HALT.
      exp_pc = 32'h40; cyc("commit40", S_NORMAL, 3'b000, 1'b1, 32'h40, 1'b0);
      exp_cause = 2'd1; cyc("h_illegal", S_SAFE, 3'b001, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) cyc("h_drain", S_SAFE, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("h_rollback", S_ROLLBACK, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("h_retry", S_RETRY, 3'b000, 1'b0, 32'h0, 1'b0);
      exp_rc = 4'd1; exp_cause = 2'd2; cyc("h_fault1", S_SAFE, 3'b010, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) cyc("h_drain2", S_SAFE, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("h_rollback2", S_ROLLBACK, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("h_retry2", S_RETRY, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("h_fault2", S_HALT, 3'b010, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("halt_hold", S_HALT, 3'b111, 1'b1, 32'h77, 1'b0);
      exp_rc = 4'd0; exp_cause = 2'd0; cyc("clear_halt", S_NORMAL, 3'b000, 1'b0, 32'h0, 1'b1);

      // Asynchronous reset in the middle of SAFE.
      exp_pc = 32'h50; cyc("commit50", S_NORMAL, 3'b000, 1'b1, 32'h50, 1'b0);
      exp_cause = 2'd1; cyc("r_illegal", S_SAFE, 3'b001, 1'b0, 32'h0, 1'b0);
      cyc("r_safe2", S_SAFE, 3'b000, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      {stuck_at_fault, invalid_control, illegal_opcode} = 3'b000;
      {pc_write_normal, reg_write_normal, mem_write_normal} = 3'b000;
      instr_commit = 1'b0;
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset");
      @(posedge clk);
      #1 check_all_zero("reset_held");
      @(negedge clk);
      reset = 1'b1;
      exp_pc = '0; exp_cause = '0; exp_rc = '0;
      for (int i = 0; i < 4; i++) cyc("post_reset", S_NORMAL, 3'b000, 1'b0, 32'h0, 1'b0);
      exp_cause = 2'd1; cyc("pr_illegal", S_SAFE, 3'b001, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) cyc("pr_drain", S_SAFE, 3'b000, 1'b0, 32'h0, 1'b0);
      cyc("pr_rollback", S_ROLLBACK, 3'b000, 1'b0, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
